// File: rtl/decode_stage_pkg.sv
// ---------------------------------------------------------------------------
// decode_stage_pkg
// Shared constants and types for the RV32I decode stage:
//   - opcode, funct3 and funct7 encodings
//   - ALU control codes (NOP is 0, PASS_B forwards operand B)
//   - immediate-format selector and the immediate builder function
//   - ctrl_t, the per-instruction field/flag bundle held in the output FIFO
// Optional feature macro: DECODE_M_EXT_EN adds the RV32M ALU codes.
// ---------------------------------------------------------------------------
package decode_stage_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // ALU-type funct3
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // Branch funct3
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Load / store / jalr funct3
  localparam logic [2:0] F3_LB   = 3'b000;
  localparam logic [2:0] F3_LH   = 3'b001;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_LBU  = 3'b100;
  localparam logic [2:0] F3_LHU  = 3'b101;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_SH   = 3'b001;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;

  // funct7 variants
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ALU control codes
  localparam logic [4:0] ALU_NOP    = 5'd0;
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_SUB    = 5'd2;
  localparam logic [4:0] ALU_SLL    = 5'd3;
  localparam logic [4:0] ALU_SLT    = 5'd4;
  localparam logic [4:0] ALU_SLTU   = 5'd5;
  localparam logic [4:0] ALU_XOR    = 5'd6;
  localparam logic [4:0] ALU_SRL    = 5'd7;
  localparam logic [4:0] ALU_SRA    = 5'd8;
  localparam logic [4:0] ALU_OR     = 5'd9;
  localparam logic [4:0] ALU_AND    = 5'd10;
  localparam logic [4:0] ALU_PASS_B = 5'd11;

`ifdef DECODE_M_EXT_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [4:0] ALU_MUL    = 5'd12;
  localparam logic [4:0] ALU_MULH   = 5'd13;
  localparam logic [4:0] ALU_MULHSU = 5'd14;
  localparam logic [4:0] ALU_MULHU  = 5'd15;
  localparam logic [4:0] ALU_DIV    = 5'd16;
  localparam logic [4:0] ALU_DIVU   = 5'd17;
  localparam logic [4:0] ALU_REM    = 5'd18;
  localparam logic [4:0] ALU_REMU   = 5'd19;
`endif

  // Which immediate layout to extract; IMM_SHAMT is the 5-bit shift amount
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT
  } imm_sel_t;

  // Raw fields and control flags for one decoded instruction
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       src_b_imm;
    logic       writeback;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  // Assemble the 32-bit sign-extended immediate for the selected format
  function automatic logic [31:0] build_imm(input logic [31:0] inst, input imm_sel_t sel);
    logic [31:0] result;
    case (sel)
      IMM_I:     result = {{20{inst[31]}}, inst[31:20]};
      IMM_S:     result = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:     result = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:     result = {inst[31:12], 12'b0};
      IMM_J:     result = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      IMM_SHAMT: result = {27'b0, inst[24:20]};
      default:   result = 32'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/decode_comb.sv
// ---------------------------------------------------------------------------
// decode_comb
// Purely combinational RV32I instruction decoder.
// Ports:
//   inst    in   32        raw instruction word
//   ctrl    out  ctrl_t    raw fields plus control flags
//   imm     out  XLEN      sign-extended immediate (0 for R-type / illegal)
//   alu_op  out  ALU_OP_W  ALU control code
// Optional feature macro: DECODE_M_EXT_EN enables the RV32M funct7 group;
// without it that group decodes as illegal.
// ---------------------------------------------------------------------------
module decode_comb
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic [31:0]         inst,
  output ctrl_t               ctrl,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  alu_code;
  imm_sel_t    imm_sel;
  logic [31:0] imm32;
  logic        src_b_d;
  logic        wb_d;
  logic        mr_d;
  logic        mw_d;
  logic        br_d;
  logic        jp_d;
  logic        ill_d;

  assign opc = inst[6:0];
  assign f3  = inst[14:12];
  assign f7  = inst[31:25];

  // Main decode. Anything not recognised sets ill_d; the tail of the block
  // then squashes every side-effecting flag so an illegal slot is inert.
  always_comb begin
    alu_code = ALU_NOP;
    imm_sel  = IMM_NONE;
    src_b_d  = 1'b0;
    wb_d     = 1'b0;
    mr_d     = 1'b0;
    mw_d     = 1'b0;
    br_d     = 1'b0;
    jp_d     = 1'b0;
    ill_d    = 1'b0;

    case (opc)
      OPC_OP: begin
        wb_d = 1'b1;
        case (f7)
          F7_BASE: begin
            case (f3)
              F3_ADD_SUB: alu_code = ALU_ADD;
              F3_SLL:     alu_code = ALU_SLL;
              F3_SLT:     alu_code = ALU_SLT;
              F3_SLTU:    alu_code = ALU_SLTU;
              F3_XOR:     alu_code = ALU_XOR;
              F3_SRL_SRA: alu_code = ALU_SRL;
              F3_OR:      alu_code = ALU_OR;
              F3_AND:     alu_code = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (f3)
              F3_ADD_SUB: alu_code = ALU_SUB;
              F3_SRL_SRA: alu_code = ALU_SRA;
              default:    ill_d    = 1'b1;
            endcase
          end
`ifdef DECODE_M_EXT_EN
          F7_MULDIV: begin
            case (f3)
              F3_MUL:    alu_code = ALU_MUL;
              F3_MULH:   alu_code = ALU_MULH;
              F3_MULHSU: alu_code = ALU_MULHSU;
              F3_MULHU:  alu_code = ALU_MULHU;
              F3_DIV:    alu_code = ALU_DIV;
              F3_DIVU:   alu_code = ALU_DIVU;
              F3_REM:    alu_code = ALU_REM;
              F3_REMU:   alu_code = ALU_REMU;
            endcase
          end
`endif
          default: ill_d = 1'b1;
        endcase
      end

      // Shifts carry their amount in imm[4:0]; the upper bits act as funct7
      // and must name a valid shift variant.
      OPC_OP_IMM: begin
        wb_d    = 1'b1;
        src_b_d = 1'b1;
        imm_sel = IMM_I;
        case (f3)
          F3_ADD_SUB: alu_code = ALU_ADD;
          F3_SLT:     alu_code = ALU_SLT;
          F3_SLTU:    alu_code = ALU_SLTU;
          F3_XOR:     alu_code = ALU_XOR;
          F3_OR:      alu_code = ALU_OR;
          F3_AND:     alu_code = ALU_AND;
          F3_SLL: begin
            imm_sel = IMM_SHAMT;
            if (f7 == F7_BASE) alu_code = ALU_SLL;
            else               ill_d    = 1'b1;
          end
          F3_SRL_SRA: begin
            imm_sel = IMM_SHAMT;
            if (f7 == F7_BASE)     alu_code = ALU_SRL;
            else if (f7 == F7_ALT) alu_code = ALU_SRA;
            else                   ill_d    = 1'b1;
          end
        endcase
      end

      OPC_LOAD: begin
        case (f3)
          F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: begin
            mr_d     = 1'b1;
            wb_d     = 1'b1;
            src_b_d  = 1'b1;
            imm_sel  = IMM_I;
            alu_code = ALU_ADD;
          end
          default: ill_d = 1'b1;
        endcase
      end

      OPC_STORE: begin
        case (f3)
          F3_SB, F3_SH, F3_SW: begin
            mw_d     = 1'b1;
            src_b_d  = 1'b1;
            imm_sel  = IMM_S;
            alu_code = ALU_ADD;
          end
          default: ill_d = 1'b1;
        endcase
      end

      // Branches compare rs1 against rs2, so operand B stays a register
      OPC_BRANCH: begin
        br_d    = 1'b1;
        imm_sel = IMM_B;
        case (f3)
          F3_BEQ, F3_BNE:   alu_code = ALU_SUB;
          F3_BLT, F3_BGE:   alu_code = ALU_SLT;
          F3_BLTU, F3_BGEU: alu_code = ALU_SLTU;
          default:          ill_d    = 1'b1;
        endcase
      end

      OPC_JAL: begin
        jp_d     = 1'b1;
        wb_d     = 1'b1;
        src_b_d  = 1'b1;
        imm_sel  = IMM_J;
        alu_code = ALU_ADD;
      end

      OPC_JALR: begin
        if (f3 == F3_JALR) begin
          jp_d     = 1'b1;
          wb_d     = 1'b1;
          src_b_d  = 1'b1;
          imm_sel  = IMM_I;
          alu_code = ALU_ADD;
        end else begin
          ill_d = 1'b1;
        end
      end

      OPC_LUI: begin
        wb_d     = 1'b1;
        src_b_d  = 1'b1;
        imm_sel  = IMM_U;
        alu_code = ALU_PASS_B;
      end

      OPC_AUIPC: begin
        wb_d     = 1'b1;
        src_b_d  = 1'b1;
        imm_sel  = IMM_U;
        alu_code = ALU_ADD;
      end

      default: ill_d = 1'b1;
    endcase

    if (ill_d) begin
      alu_code = ALU_NOP;
      imm_sel  = IMM_NONE;
      src_b_d  = 1'b0;
      wb_d     = 1'b0;
      mr_d     = 1'b0;
      mw_d     = 1'b0;
      br_d     = 1'b0;
      jp_d     = 1'b0;
    end
  end

  assign imm32  = build_imm(inst, imm_sel);
  assign imm    = XLEN'($signed(imm32));
  assign alu_op = ALU_OP_W'(alu_code);

  // Writes to x0 are architecturally discarded, so writeback is dropped here
  always_comb begin
    ctrl.opcode    = opc;
    ctrl.funct3    = f3;
    ctrl.funct7    = f7;
    ctrl.rs1       = inst[19:15];
    ctrl.rs2       = inst[24:20];
    ctrl.rd        = inst[11:7];
    ctrl.src_b_imm = src_b_d;
    ctrl.writeback = wb_d && (inst[11:7] != 5'd0);
    ctrl.mem_read  = mr_d;
    ctrl.mem_write = mw_d;
    ctrl.branch    = br_d;
    ctrl.jump      = jp_d;
    ctrl.illegal   = ill_d;
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// Registered RV32I decode stage between fetch and execute. Each accepted
// instruction is decoded combinationally and written into a DEPTH-entry
// FIFO; the head entry drives the outputs.
// Ports:
//   clk, rst_n (synchronous, active-low), flush (drop everything this edge)
//   in_valid/in_ready, inst_encoding[31:0], in_pc[XLEN-1:0]   fetch side
//   out_valid/out_ready, pc, opcode, funct3, funct7, rs1, rs2, rd, imm,
//   alu_op, src_b_imm, writeback, mem_read, mem_write, branch, jump,
//   illegal                                                   execute side
// Parameters: XLEN, ALU_OP_W, DEPTH (power of two, >= 2).
// Optional feature macro: DECODE_M_EXT_EN (RV32M decode in decode_comb).
// ---------------------------------------------------------------------------
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5,
  parameter int DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         inst_encoding,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     pc,
  output logic [6:0]          opcode,
  output logic [2:0]          funct3,
  output logic [6:0]          funct7,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [4:0]          rd,
  output logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                src_b_imm,
  output logic                writeback,
  output logic                mem_read,
  output logic                mem_write,
  output logic                branch,
  output logic                jump,
  output logic                illegal
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);

  ctrl_t                dec_ctrl;
  logic [XLEN-1:0]      dec_imm;
  logic [ALU_OP_W-1:0]  dec_alu_op;

  ctrl_t                ctrl_mem [DEPTH];
  logic [XLEN-1:0]      imm_mem  [DEPTH];
  logic [XLEN-1:0]      pc_mem   [DEPTH];
  logic [ALU_OP_W-1:0]  alu_mem  [DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  ctrl_t                head;

  decode_comb #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode_comb (
    .inst   (inst_encoding),
    .ctrl   (dec_ctrl),
    .imm    (dec_imm),
    .alu_op (dec_alu_op)
  );

  // Both handshake outputs come from the registered count only, so there is
  // no combinational path from out_ready to in_ready; they are additionally
  // held low while reset is asserted.
  assign in_ready  = rst_n && (count < FULL_COUNT);
  assign out_valid = rst_n && (count != '0);

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  // FIFO state. Reset clears the storage as well, so every output reads 0
  // after reset; flush only empties the pointers and count. Pointers wrap
  // naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_mem[i] <= '0;
        imm_mem[i]  <= '0;
        pc_mem[i]   <= '0;
        alu_mem[i]  <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ctrl_mem[wr_ptr] <= dec_ctrl;
        imm_mem[wr_ptr]  <= dec_imm;
        pc_mem[wr_ptr]   <= in_pc;
        alu_mem[wr_ptr]  <= dec_alu_op;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head entry drives the outputs directly from storage
  assign head      = ctrl_mem[rd_ptr];
  assign pc        = pc_mem[rd_ptr];
  assign imm       = imm_mem[rd_ptr];
  assign alu_op    = alu_mem[rd_ptr];
  assign opcode    = head.opcode;
  assign funct3    = head.funct3;
  assign funct7    = head.funct7;
  assign rs1       = head.rs1;
  assign rs2       = head.rs2;
  assign rd        = head.rd;
  assign src_b_imm = head.src_b_imm;
  assign writeback = head.writeback;
  assign mem_read  = head.mem_read;
  assign mem_write = head.mem_write;
  assign branch    = head.branch;
  assign jump      = head.jump;
  assign illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
// Scoreboard bench for decode_stage. The driver pushes a hand-computed
// expected record whenever the DUT accepts an instruction; a monitor pops
// and compares whenever the DUT hands an entry to execute.
// Flag vectors are ordered {src_b_imm, writeback, mem_read, mem_write,
// branch, jump, illegal}.
// Optional feature macro: DECODE_M_EXT_EN changes the expected MUL decode.
// ---------------------------------------------------------------------------
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 5;
  localparam int DEPTH    = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         inst_encoding;
  logic [XLEN-1:0]     in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [XLEN-1:0]     pc;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [4:0]          rd;
  logic [XLEN-1:0]     imm;
  logic [ALU_OP_W-1:0] alu_op;
  logic                src_b_imm;
  logic                writeback;
  logic                mem_read;
  logic                mem_write;
  logic                branch;
  logic                jump;
  logic                illegal;
  logic [6:0]          dut_flags;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [6:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   assertions = 0;
  int   failures   = 0;

  always #5 clk = ~clk;

  decode_stage #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W),
    .DEPTH    (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .inst_encoding (inst_encoding),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pc            (pc),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .rs1           (rs1),
    .rs2           (rs2),
    .rd            (rd),
    .imm           (imm),
    .alu_op        (alu_op),
    .src_b_imm     (src_b_imm),
    .writeback     (writeback),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .branch        (branch),
    .jump          (jump),
    .illegal       (illegal)
  );

  assign dut_flags = {src_b_imm, writeback, mem_read, mem_write, branch, jump, illegal};

  function automatic exp_t mk(input logic [31:0] p, input logic [4:0] r, input logic [31:0] i,
                              input logic [4:0] a, input logic [6:0] f);
    exp_t e;
    e.pc    = p;
    e.rd    = r;
    e.imm   = i;
    e.alu   = a;
    e.flags = f;
    return e;
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one instruction and hold it until accepted; the expected record is
  // queued at the sample point just before the accepting edge.
  task automatic apply_stimulus(input logic [31:0] inst, input logic [31:0] addr, input exp_t e);
    bit accepted = 1'b0;
    int waited   = 0;
    inst_encoding = inst;
    in_pc         = addr;
    in_valid      = 1'b1;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (in_ready && !flush && rst_n) begin
        accepted = 1'b1;
        sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      assertions++;
      failures++;
      $display("[TB] FAIL accept_timeout: pc 0x%0h never accepted", addr);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_output("drain_queue_empty", 64'(sb_q.size()), 64'd0);
    check_output("drain_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_output({tag, "_in_ready"},  64'(in_ready),  64'd0);
    check_output({tag, "_pc"},        64'(pc),        64'd0);
    check_output({tag, "_imm"},       64'(imm),       64'd0);
    check_output({tag, "_alu_op"},    64'(alu_op),    64'd0);
    check_output({tag, "_flags"},     64'(dut_flags), 64'd0);
    check_output({tag, "_opcode"},    64'(opcode),    64'd0);
    check_output({tag, "_rd"},        64'(rd),        64'd0);
  endtask

  // Monitor: compares the head entry on every cycle execute consumes it
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n || flush) begin
      sb_q.delete();
    end else if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        assertions++;
        failures++;
        $display("[TB] FAIL unexpected_output: pc 0x%0h with empty scoreboard", pc);
      end else begin
        e = sb_q.pop_front();
        check_output("out_pc",    64'(pc),        64'(e.pc));
        check_output("out_rd",    64'(rd),        64'(e.rd));
        check_output("out_imm",   64'(imm),       64'(e.imm));
        check_output("out_alu",   64'(alu_op),    64'(e.alu));
        check_output("out_flags", 64'(dut_flags), 64'(e.flags));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst_n         = 1'b0;
    flush         = 1'b1;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    inst_encoding = 32'h0;
    in_pc         = 32'h0;

    // Reset with flush also asserted: flush must have no effect
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    flush = 1'b0;
    #1;
    check_output("ready_after_reset", 64'(in_ready), 64'd1);

    // Streaming decode with execute always ready
    out_ready = 1'b1;
    apply_stimulus(32'h00500093, 32'h100, mk(32'h100, 5'd1,  32'h5,        ALU_ADD,    7'b1100000));
    check_output("latency_one_cycle", 64'(out_valid), 64'd1);
    apply_stimulus(32'h402081B3, 32'h104, mk(32'h104, 5'd3,  32'h0,        ALU_SUB,    7'b0100000));
    apply_stimulus(32'hFFC12283, 32'h108, mk(32'h108, 5'd5,  32'hFFFFFFFC, ALU_ADD,    7'b1110000));
    apply_stimulus(32'hFE208CE3, 32'h10C, mk(32'h10C, 5'd25, 32'hFFFFFFF8, ALU_SUB,    7'b0000100));
    apply_stimulus(32'h123453B7, 32'h110, mk(32'h110, 5'd7,  32'h12345000, ALU_PASS_B, 7'b1100000));
    apply_stimulus(32'h0020A423, 32'h114, mk(32'h114, 5'd8,  32'h8,        ALU_ADD,    7'b1001000));
    apply_stimulus(32'h010000EF, 32'h118, mk(32'h118, 5'd1,  32'h10,       ALU_ADD,    7'b1100010));
    apply_stimulus(32'h4030D213, 32'h11C, mk(32'h11C, 5'd4,  32'h3,        ALU_SRA,    7'b1100000));
    apply_stimulus(32'h00000013, 32'h120, mk(32'h120, 5'd0,  32'h0,        ALU_ADD,    7'b1000000));
    apply_stimulus(32'hFFFFFFFF, 32'h124, mk(32'h124, 5'd31, 32'h0,        ALU_NOP,    7'b0000001));
    apply_stimulus(32'h0020A063, 32'h128, mk(32'h128, 5'd0,  32'h0,        ALU_NOP,    7'b0000001));
    apply_stimulus(32'h0020C463, 32'h12C, mk(32'h12C, 5'd8,  32'h8,        ALU_SLT,    7'b0000100));
`ifdef DECODE_M_EXT_EN
    apply_stimulus(32'h022081B3, 32'h130, mk(32'h130, 5'd3,  32'h0,        ALU_MUL,    7'b0100000));
`else
    apply_stimulus(32'h022081B3, 32'h130, mk(32'h130, 5'd3,  32'h0,        ALU_NOP,    7'b0000001));
`endif
    wait_drain();

    // Backpressure: two entries fill the buffer, the third waits
    out_ready = 1'b0;
    apply_stimulus(32'h00700113, 32'h200, mk(32'h200, 5'd2, 32'h7,        ALU_ADD, 7'b1100000));
    apply_stimulus(32'hFFF00193, 32'h204, mk(32'h204, 5'd3, 32'hFFFFFFFF, ALU_ADD, 7'b1100000));
    check_output("full_in_ready", 64'(in_ready),  64'd0);
    check_output("full_out_valid", 64'(out_valid), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check_output("stall_hold_pc",  64'(pc),  64'h200);
    check_output("stall_hold_imm", 64'(imm), 64'h7);
    fork
      apply_stimulus(32'h0F00F213, 32'h208, mk(32'h208, 5'd4, 32'hF0, ALU_AND, 7'b1100000));
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_output("full_pop_in_ready", 64'(in_ready), 64'd0);
      end
    join
    wait_drain();

    // Flush with two entries buffered and a valid input on the same edge
    out_ready = 1'b0;
    apply_stimulus(32'h00700113, 32'h300, mk(32'h300, 5'd2, 32'h7, ALU_ADD, 7'b1100000));
    apply_stimulus(32'h402081B3, 32'h304, mk(32'h304, 5'd3, 32'h0, ALU_SUB, 7'b0100000));
    inst_encoding = 32'h123453B7;
    in_pc         = 32'h308;
    in_valid      = 1'b1;
    flush         = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check_output("flush_out_valid", 64'(out_valid), 64'd0);
    check_output("flush_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    apply_stimulus(32'h402081B3, 32'h30C, mk(32'h30C, 5'd3, 32'h0, ALU_SUB, 7'b0100000));
    wait_drain();

    // Reset in the middle of a stalled stream
    out_ready = 1'b0;
    apply_stimulus(32'h123453B7, 32'h400, mk(32'h400, 5'd7, 32'h12345000, ALU_PASS_B, 7'b1100000));
    apply_stimulus(32'hFFC12283, 32'h404, mk(32'h404, 5'd5, 32'hFFFFFFFC, ALU_ADD,    7'b1110000));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst_n = 1'b1;
    #1;
    check_output("ready_after_midreset", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    apply_stimulus(32'h00500093, 32'h408, mk(32'h408, 5'd1, 32'h5, ALU_ADD, 7'b1100000));
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
